// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port register file with write-through bypass and an
// issue/writeback scoreboard that reports pending destinations per read port.
module regfile_mp_sb #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 16,
    parameter int  NUM_RD   = 4,
    parameter int  NUM_WR   = 2,
    parameter int  ZERO_REG = 0,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        rsv_en,
    input  logic [NUM_WR*AW-1:0]     rsv_addr,
    input  logic                     flush,
    output logic [AW:0]              pend_cnt
);

    localparam int NSLOT = 1 << AW;

    // Bit r set when address r names a real, writable register.
    function automatic logic [NSLOT-1:0] slot_mask();
        logic [NSLOT-1:0] m;
        m = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            m[r] = !((ZERO_REG != 0) && (r == 0));
        end
        return m;
    endfunction

    localparam logic [NSLOT-1:0] RD_MASK = slot_mask();

    logic [DATA_W-1:0]   r_regs     [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [AW:0]         r_pend_cnt;

    logic [DATA_W-1:0]   w_regs_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] w_pend_nxt;
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_rsv_hit;
    logic [AW:0]         w_pend_pop;

    logic [AW-1:0]       w_rd_addr  [NUM_RD];
    logic [DATA_W-1:0]   w_rd_val   [NUM_RD];
    logic [NUM_RD-1:0]   w_rd_byp;

    assign pend_cnt = r_pend_cnt;

    // Next-state data and pending bits; ascending port order lets the highest write port win.
    always_comb begin
        w_regs_nxt = r_regs;
        w_wr_hit   = '0;
        w_rsv_hit  = '0;
        w_pend_nxt = '0;
        w_pend_pop = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                w_regs_nxt[r] = (wr_en[j] && RD_MASK[r] && (wr_addr[j*AW +: AW] == AW'(r)))
                              ? wr_data[j*DATA_W +: DATA_W] : w_regs_nxt[r];
                w_wr_hit[r]   = w_wr_hit[r]
                              | (wr_en[j] & RD_MASK[r] & (wr_addr[j*AW +: AW] == AW'(r)));
                w_rsv_hit[r]  = w_rsv_hit[r]
                              | (rsv_en[j] & RD_MASK[r] & (rsv_addr[j*AW +: AW] == AW'(r)));
            end
            // A reserve installs a new producer, so it outranks a same-cycle writeback.
            w_pend_nxt[r] = flush        ? 1'b0 :
                            w_rsv_hit[r] ? 1'b1 :
                            w_wr_hit[r]  ? 1'b0 : r_pend[r];
            w_pend_pop    = w_pend_pop + (AW+1)'(w_pend_nxt[r]);
        end
    end

    // State update; reset drops every write, reserve and flush of the cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regs     <= '{default: '0};
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_regs     <= w_regs_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_pend_pop;
        end
    end

    // Combinational read with write-through bypass and hazard report.
    always_comb begin
        rd_data  = '0;
        rd_busy  = '0;
        w_rd_byp = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_addr[i] = rd_addr[i*AW +: AW];
            w_rd_val[i]  = '0;
            if (rst_n && RD_MASK[w_rd_addr[i]]) begin
                w_rd_val[i] = r_regs[w_rd_addr[i]];
                for (int j = 0; j < NUM_WR; j++) begin
                    w_rd_val[i] = (wr_en[j] && (wr_addr[j*AW +: AW] == w_rd_addr[i]))
                                ? wr_data[j*DATA_W +: DATA_W] : w_rd_val[i];
                    w_rd_byp[i] = w_rd_byp[i]
                                | (wr_en[j] & (wr_addr[j*AW +: AW] == w_rd_addr[i]));
                end
                rd_busy[i] = r_pend[w_rd_addr[i]] & ~w_rd_byp[i];
            end else begin
                rd_busy[i] = 1'b0;
            end
            rd_data[i*DATA_W +: DATA_W] = w_rd_val[i];
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a default instance and a ZERO_REG/12-entry instance
// driven by directed and random steps, checked against an array-based model.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (16 regs, 4R, 2W, no zero register)
    logic        a_rst_n;
    logic [15:0] a_rd_addr;
    logic [63:0] a_rd_data;
    logic [3:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [7:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [1:0]  a_rsv_en;
    logic [7:0]  a_rsv_addr;
    logic        a_flush;
    logic [4:0]  a_pend_cnt;

    // Instance Z: 12 regs, 3R, 3W, zero register
    logic        z_rst_n;
    logic [11:0] z_rd_addr;
    logic [47:0] z_rd_data;
    logic [2:0]  z_rd_busy;
    logic [2:0]  z_wr_en;
    logic [11:0] z_wr_addr;
    logic [47:0] z_wr_data;
    logic [2:0]  z_rsv_en;
    logic [11:0] z_rsv_addr;
    logic        z_flush;
    logic [4:0]  z_pend_cnt;

    regfile_mp_sb u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .flush(a_flush), .pend_cnt(a_pend_cnt)
    );

    regfile_mp_sb #(.DATA_W(16), .NUM_REGS(12), .NUM_RD(3), .NUM_WR(3), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .rst_n(z_rst_n), .rd_addr(z_rd_addr), .rd_data(z_rd_data),
        .rd_busy(z_rd_busy), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr), .flush(z_flush), .pend_cnt(z_pend_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Stimulus of the current cycle, per instance d (0 = A, 1 = Z)
    int m_rstn [2];
    int m_we   [2][3];
    int m_wa   [2][3];
    int m_wd   [2][3];
    int m_re   [2][3];
    int m_ra   [2][3];
    int m_fl   [2];
    int m_rda  [2][4];
    // Architectural state of the model
    int mem    [2][16];
    int pend   [2][16];
    int cnt    [2];

    function automatic int nregs(int d); return (d != 0) ? 12 : 16; endfunction
    function automatic int nwr(int d);   return (d != 0) ? 3 : 2;   endfunction
    function automatic int nrd(int d);   return (d != 0) ? 3 : 4;   endfunction

    function automatic int usable(int d, int a);
        return (a < nregs(d)) && !((d != 0) && (a == 0));
    endfunction

    // Highest write port targeting a this cycle, or -1
    function automatic int wr_hit(int d, int a);
        int h;
        h = -1;
        for (int j = 0; j < nwr(d); j++)
            if (m_we[d][j] != 0 && m_wa[d][j] == a) h = j;
        return h;
    endfunction

    function automatic int exp_rd(int d, int i);
        int a, h;
        a = m_rda[d][i];
        if (m_rstn[d] == 0 || usable(d, a) == 0) return 0;
        h = wr_hit(d, a);
        return (h >= 0) ? m_wd[d][h] : mem[d][a];
    endfunction

    function automatic int exp_busy(int d, int i);
        int a;
        a = m_rda[d][i];
        if (m_rstn[d] == 0 || usable(d, a) == 0) return 0;
        return (pend[d][a] != 0 && wr_hit(d, a) < 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] obs_rd(int d, int i);
        return (d != 0) ? 32'(z_rd_data[i*16 +: 16]) : 32'(a_rd_data[i*16 +: 16]);
    endfunction

    function automatic logic [31:0] obs_busy(int d, int i);
        return (d != 0) ? 32'(z_rd_busy[i]) : 32'(a_rd_busy[i]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        a_rst_n = (m_rstn[0] != 0);
        z_rst_n = (m_rstn[1] != 0);
        a_flush = (m_fl[0] != 0);
        z_flush = (m_fl[1] != 0);
        for (int j = 0; j < 2; j++) begin
            a_wr_en[j]           = (m_we[0][j] != 0);
            a_wr_addr[j*4 +: 4]  = 4'(m_wa[0][j]);
            a_wr_data[j*16 +: 16] = 16'(m_wd[0][j]);
            a_rsv_en[j]          = (m_re[0][j] != 0);
            a_rsv_addr[j*4 +: 4] = 4'(m_ra[0][j]);
        end
        for (int j = 0; j < 3; j++) begin
            z_wr_en[j]           = (m_we[1][j] != 0);
            z_wr_addr[j*4 +: 4]  = 4'(m_wa[1][j]);
            z_wr_data[j*16 +: 16] = 16'(m_wd[1][j]);
            z_rsv_en[j]          = (m_re[1][j] != 0);
            z_rsv_addr[j*4 +: 4] = 4'(m_ra[1][j]);
        end
        for (int i = 0; i < 4; i++) a_rd_addr[i*4 +: 4] = 4'(m_rda[0][i]);
        for (int i = 0; i < 3; i++) z_rd_addr[i*4 +: 4] = 4'(m_rda[1][i]);
    endtask

    // Apply the stimulus, then check every combinational read output.
    task automatic drive();
        apply();
        #2;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < nrd(d); i++) begin
                chk($sformatf("rd_data d%0d p%0d a%0d", d, i, m_rda[d][i]), obs_rd(d, i), 32'(exp_rd(d, i)));
                chk($sformatf("rd_busy d%0d p%0d a%0d", d, i, m_rda[d][i]), obs_busy(d, i), 32'(exp_busy(d, i)));
            end
    endtask

    task automatic update_model(input int d);
        int np [16];
        int rs, wr;
        if (m_rstn[d] == 0) begin
            for (int r = 0; r < 16; r++) begin mem[d][r] = 0; pend[d][r] = 0; end
        end else begin
            for (int j = 0; j < nwr(d); j++)
                if (m_we[d][j] != 0 && usable(d, m_wa[d][j]) != 0) mem[d][m_wa[d][j]] = m_wd[d][j];
            for (int r = 0; r < 16; r++) begin
                rs = 0;
                wr = 0;
                for (int j = 0; j < nwr(d); j++) begin
                    if (m_re[d][j] != 0 && m_ra[d][j] == r) rs = 1;
                    if (m_we[d][j] != 0 && m_wa[d][j] == r) wr = 1;
                end
                if (usable(d, r) == 0)  np[r] = 0;
                else if (m_fl[d] != 0)  np[r] = 0;
                else if (rs != 0)       np[r] = 1;
                else if (wr != 0)       np[r] = 0;
                else                    np[r] = pend[d][r];
            end
            for (int r = 0; r < 16; r++) pend[d][r] = np[r];
        end
        cnt[d] = 0;
        for (int r = 0; r < 16; r++) cnt[d] += pend[d][r];
    endtask

    // Clock edge: advance the model, check pend_cnt, clear one-shot controls.
    task automatic tick();
        @(posedge clk);
        update_model(0);
        update_model(1);
        #2;
        chk("pend_cnt d0", 32'(a_pend_cnt), 32'(cnt[0]));
        chk("pend_cnt d1", 32'(z_pend_cnt), 32'(cnt[1]));
        for (int d = 0; d < 2; d++) begin
            m_fl[d] = 0;
            for (int j = 0; j < 3; j++) begin m_we[d][j] = 0; m_re[d][j] = 0; end
        end
    endtask

    task automatic random_inputs(input int d);
        m_rstn[d] = ($urandom_range(0, 63) != 0) ? 1 : 0;
        m_fl[d]   = ($urandom_range(0, 15) == 0) ? 1 : 0;
        for (int j = 0; j < nwr(d); j++) begin
            m_we[d][j] = int'($urandom_range(0, 1));
            m_wa[d][j] = int'($urandom_range(0, 15));
            m_wd[d][j] = int'($urandom_range(0, 16'hFFFF));
            m_re[d][j] = ($urandom_range(0, 3) == 0) ? 1 : 0;
            m_ra[d][j] = int'($urandom_range(0, 15));
        end
        for (int i = 0; i < nrd(d); i++)
            m_rda[d][i] = ($urandom_range(0, 2) == 0) ? m_wa[d][0] : int'($urandom_range(0, 15));
    endtask

    initial begin
        // Reset held two cycles with a write pending on R3
        m_rstn[0] = 0;
        m_rstn[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_we[0][0] = 1; m_wa[0][0] = 3; m_wd[0][0] = 16'h7777;
            m_we[1][0] = 1; m_wa[1][0] = 3; m_wd[1][0] = 16'h7777;
            drive();
            tick();
        end
        chk("reset pend_cnt", 32'(a_pend_cnt), 32'd0);
        chk("reset rd0", 32'(a_rd_data[15:0]), 32'd0);

        m_rstn[0] = 1;
        m_rstn[1] = 1;
        m_we[0][0] = 1; m_wa[0][0] = 1; m_wd[0][0] = 16'h1234; m_rda[0][0] = 1; m_rda[0][1] = 3;
        drive();
        chk("bypass R1", 32'(a_rd_data[15:0]), 32'h1234);
        tick();
        drive();
        chk("stored R1", 32'(a_rd_data[15:0]), 32'h1234);
        chk("R3 not written in reset", 32'(a_rd_data[31:16]), 32'd0);
        tick();

        // Same-address write priority
        m_we[0][0] = 1; m_wa[0][0] = 5; m_wd[0][0] = 16'hBEEF;
        m_we[0][1] = 1; m_wa[0][1] = 5; m_wd[0][1] = 16'hCAFE; m_rda[0][1] = 5;
        drive();
        chk("prio bypass", 32'(a_rd_data[31:16]), 32'hCAFE);
        tick();
        drive();
        chk("prio stored", 32'(a_rd_data[31:16]), 32'hCAFE);
        tick();

        // Scoreboard life cycle
        m_re[0][0] = 1; m_ra[0][0] = 2; m_re[0][1] = 1; m_ra[0][1] = 7;
        m_rda[0][2] = 2; m_rda[0][3] = 7;
        drive();
        chk("reserve not busy same cycle", 32'(a_rd_busy[3:2]), 32'd0);
        tick();
        chk("pend_cnt two", 32'(a_pend_cnt), 32'd2);
        drive();
        chk("busy R2 R7", 32'(a_rd_busy[3:2]), 32'd3);
        tick();
        m_we[0][0] = 1; m_wa[0][0] = 2; m_wd[0][0] = 16'hABCD;
        drive();
        chk("writeback clears busy", 32'(a_rd_busy[2]), 32'd0);
        chk("writeback bypass", 32'(a_rd_data[47:32]), 32'hABCD);
        tick();
        chk("pend_cnt one", 32'(a_pend_cnt), 32'd1);
        m_fl[0] = 1;
        drive();
        tick();
        chk("flush pend_cnt", 32'(a_pend_cnt), 32'd0);
        drive();
        chk("R7 free after flush", 32'(a_rd_busy[3]), 32'd0);
        tick();

        // Simultaneous reserve + write, then flush + reserve
        m_re[0][0] = 1; m_ra[0][0] = 4;
        m_we[0][1] = 1; m_wa[0][1] = 4; m_wd[0][1] = 16'h1111; m_rda[0][0] = 4;
        drive();
        tick();
        chk("reserve beats write cnt", 32'(a_pend_cnt), 32'd1);
        drive();
        chk("R4 still pending", 32'(a_rd_busy[0]), 32'd1);
        chk("R4 data", 32'(a_rd_data[15:0]), 32'h1111);
        tick();
        m_fl[0] = 1; m_re[0][0] = 1; m_ra[0][0] = 6; m_rda[0][1] = 6;
        drive();
        tick();
        chk("flush beats reserve", 32'(a_pend_cnt), 32'd0);
        drive();
        chk("R6 not busy", 32'(a_rd_busy[1]), 32'd0);
        tick();

        // Zero register / non-power-of-two depth instance
        m_we[1][0] = 1; m_wa[1][0] = 0; m_wd[1][0] = 16'hFFFF; m_rda[1][0] = 0;
        drive();
        chk("zero reg bypass", 32'(z_rd_data[15:0]), 32'd0);
        tick();
        m_re[1][0] = 1; m_ra[1][0] = 0;
        drive();
        chk("zero reg stored", 32'(z_rd_data[15:0]), 32'd0);
        tick();
        chk("zero reg reserve", 32'(z_pend_cnt), 32'd0);
        m_we[1][1] = 1; m_wa[1][1] = 13; m_wd[1][1] = 16'hDEAD; m_rda[1][1] = 13;
        drive();
        chk("out of range bypass", 32'(z_rd_data[31:16]), 32'd0);
        tick();
        drive();
        chk("out of range read", 32'(z_rd_data[31:16]), 32'd0);
        tick();
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 3; k++)
                if (1 + g*3 + k <= 11) begin
                    m_re[1][k] = 1;
                    m_ra[1][k] = 1 + g*3 + k;
                end
            drive();
            tick();
        end
        chk("all reserved", 32'(z_pend_cnt), 32'd11);
        m_rda[1][2] = 11;
        drive();
        chk("R11 busy", 32'(z_rd_busy[2]), 32'd1);
        tick();

        // Reset in the middle of operation
        m_we[0][0] = 1; m_wa[0][0] = 9; m_wd[0][0] = 16'h5A5A;
        drive();
        tick();
        m_re[0][0] = 1; m_ra[0][0] = 9; m_rda[0][0] = 9;
        drive();
        tick();
        drive();
        chk("R9 busy", 32'(a_rd_busy[0]), 32'd1);
        chk("R9 data", 32'(a_rd_data[15:0]), 32'h5A5A);
        tick();
        m_rstn[0] = 0; m_we[0][0] = 1; m_wa[0][0] = 9; m_wd[0][0] = 16'h0F0F;
        drive();
        chk("read in reset", 32'(a_rd_data[15:0]), 32'd0);
        tick();
        chk("mid reset pend_cnt", 32'(a_pend_cnt), 32'd0);
        m_rstn[0] = 1;
        drive();
        chk("R9 cleared", 32'(a_rd_data[15:0]), 32'd0);
        chk("R9 not busy", 32'(a_rd_busy[0]), 32'd0);
        tick();

        // Random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            random_inputs(0);
            random_inputs(1);
            drive();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
